// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings for the byte-serial memory controller:
//               access widths, query types, FSM states, the default IO
//               window selector and the width-to-byte-count decode.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Access width encodings on lsb_data_width
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    // Query type encodings on lsb_query_type
    localparam logic QRY_READ  = 1'b0;
    localparam logic QRY_WRITE = 1'b1;

    // addr[17:16] value that marks an IO-mapped address
    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of byte transfers for an access width (unknown widths act as word)
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Sole owner of the byte-serial RAM/IO port. Arbitrates between
//               instruction fetch (word reads) and the load/store buffer
//               (1/2/4-byte reads and writes), serialises each access into
//               byte transfers, reassembles read data little-endian and
//               returns a one-cycle reply pulse to the granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,

    input  logic        if_query_en,
    input  logic [31:0] if_query_addr,
    output logic        if_reply_en,
    output logic [31:0] if_reply_data,

    input  logic        lsb_query_en,
    input  logic        lsb_query_type,
    input  logic [31:0] lsb_query_addr,
    input  logic [1:0]  lsb_data_width,
    input  logic [31:0] lsb_query_data,
    output logic        lsb_reply_en,
    output logic [31:0] lsb_reply_data,

    input  logic        flush_signal
);

    // ------------------------------------------------------------------
    // State registers.
    // cnt meaning depends on the state:
    //   READ  : index of the edge about to happen, counted from the grant
    //           edge (grant edge = 0, so it starts at 1).
    //   WRITE : index of the byte currently on the bus.
    // ------------------------------------------------------------------
    state_t      state,     state_nx;
    logic [2:0]  cnt,       cnt_nx;
    logic [2:0]  n_bytes,   n_bytes_nx;
    logic        owner_lsb, owner_lsb_nx;
    logic [31:0] base_addr, base_addr_nx;
    logic [31:0] wdata,     wdata_nx;
    logic [31:0] result,    result_nx;

    logic [7:0]  mem_dout_nx;
    logic [31:0] mem_a_nx;
    logic        mem_wr_nx;
    logic        if_reply_en_nx;
    logic [31:0] if_reply_data_nx;
    logic        lsb_reply_en_nx;
    logic [31:0] lsb_reply_data_nx;

    // Read data with the byte sampled at this edge merged in. The byte
    // arriving now belongs to the address driven two edges earlier.
    logic [31:0] assembled;
    assign assembled = result | ({24'd0, mem_din} << {cnt - 3'd2, 3'b000});

    // Write path helpers: next byte index and its data lane
    logic [2:0]  k_inc;
    logic [31:0] wdata_shift;
    logic [7:0]  write_byte;
    logic        io_stall;

    assign k_inc       = cnt + 3'd1;
    assign wdata_shift = wdata >> {k_inc, 3'b000};
    assign write_byte  = wdata_shift[7:0];
    // The IO window check uses the base address of the access
    assign io_stall    = (base_addr[17:16] == IO_SEL) && io_buffer_full;

    // Next-state and next-output logic; everything leaves through registers
    always_comb begin
        state_nx          = state;
        cnt_nx            = cnt;
        n_bytes_nx        = n_bytes;
        owner_lsb_nx      = owner_lsb;
        base_addr_nx      = base_addr;
        wdata_nx          = wdata;
        result_nx         = result;
        mem_dout_nx       = mem_dout;
        mem_a_nx          = mem_a;
        mem_wr_nx         = mem_wr;
        if_reply_en_nx    = 1'b0;
        if_reply_data_nx  = if_reply_data;
        lsb_reply_en_nx   = 1'b0;
        lsb_reply_data_nx = lsb_reply_data;

        case (state)
            ST_IDLE: begin
                // A flush only suppresses the grant in this cycle
                if (!flush_signal) begin
                    if (lsb_query_en) begin
                        owner_lsb_nx = 1'b1;
                        base_addr_nx = lsb_query_addr;
                        n_bytes_nx   = byte_count(lsb_data_width);
                        wdata_nx     = lsb_query_data;
                        result_nx    = 32'd0;
                        mem_a_nx     = lsb_query_addr;
                        if (lsb_query_type == QRY_WRITE) begin
                            cnt_nx      = 3'd0;
                            mem_wr_nx   = 1'b1;
                            mem_dout_nx = lsb_query_data[7:0];
                            state_nx    = ST_WRITE;
                        end else begin
                            cnt_nx    = 3'd1;
                            mem_wr_nx = 1'b0;
                            state_nx  = ST_READ;
                        end
                    end else if (if_query_en) begin
                        owner_lsb_nx = 1'b0;
                        base_addr_nx = if_query_addr;
                        n_bytes_nx   = 3'd4;
                        result_nx    = 32'd0;
                        mem_a_nx     = if_query_addr;
                        mem_wr_nx    = 1'b0;
                        cnt_nx       = 3'd1;
                        state_nx     = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (flush_signal) begin
                    // Speculative read is dropped without a reply
                    mem_a_nx = 32'd0;
                    cnt_nx   = 3'd0;
                    state_nx = ST_IDLE;
                end else begin
                    mem_a_nx = (cnt < n_bytes) ? base_addr + {29'd0, cnt} : 32'd0;
                    if (cnt >= 3'd2) begin
                        result_nx = assembled;
                    end
                    if (cnt == n_bytes + 3'd1) begin
                        if (owner_lsb) begin
                            lsb_reply_en_nx   = 1'b1;
                            lsb_reply_data_nx = assembled;
                        end else begin
                            if_reply_en_nx    = 1'b1;
                            if_reply_data_nx  = assembled;
                        end
                        cnt_nx   = 3'd0;
                        state_nx = ST_DONE;
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                end
            end

            ST_WRITE: begin
                // Stores are already committed, so flush is ignored here
                if (mem_wr) begin
                    if (k_inc == n_bytes) begin
                        mem_wr_nx         = 1'b0;
                        mem_a_nx          = 32'd0;
                        mem_dout_nx       = 8'd0;
                        lsb_reply_en_nx   = 1'b1;
                        lsb_reply_data_nx = wdata;
                        cnt_nx            = 3'd0;
                        state_nx          = ST_DONE;
                    end else begin
                        cnt_nx      = k_inc;
                        mem_a_nx    = base_addr + {29'd0, k_inc};
                        mem_dout_nx = write_byte;
                        mem_wr_nx   = !io_stall;
                    end
                end else begin
                    // Byte held back by a full IO sink: retry the same byte
                    mem_wr_nx = !io_stall;
                end
            end

            ST_DONE: begin
                // Gap cycle so a requester still holding query_en is not re-granted
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            cnt            <= 3'd0;
            n_bytes        <= 3'd0;
            owner_lsb      <= 1'b0;
            base_addr      <= 32'd0;
            wdata          <= 32'd0;
            result         <= 32'd0;
            mem_dout       <= 8'd0;
            mem_a          <= 32'd0;
            mem_wr         <= 1'b0;
            if_reply_en    <= 1'b0;
            if_reply_data  <= 32'd0;
            lsb_reply_en   <= 1'b0;
            lsb_reply_data <= 32'd0;
        end else if (rdy_in) begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            n_bytes        <= n_bytes_nx;
            owner_lsb      <= owner_lsb_nx;
            base_addr      <= base_addr_nx;
            wdata          <= wdata_nx;
            result         <= result_nx;
            mem_dout       <= mem_dout_nx;
            mem_a          <= mem_a_nx;
            mem_wr         <= mem_wr_nx;
            if_reply_en    <= if_reply_en_nx;
            if_reply_data  <= if_reply_data_nx;
            lsb_reply_en   <= lsb_reply_en_nx;
            lsb_reply_data <= lsb_reply_data_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Scoreboard bench for mem_ctrl. Stimulus pushes expected
//               replies and bus writes (with the cycle they must appear in);
//               a negedge monitor pops and compares whenever the DUT shows
//               a reply pulse or a write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_query_en;
    logic [31:0] if_query_addr;
    logic        if_reply_en;
    logic [31:0] if_reply_data;
    logic        lsb_query_en;
    logic        lsb_query_type;
    logic [31:0] lsb_query_addr;
    logic [1:0]  lsb_data_width;
    logic [31:0] lsb_query_data;
    logic        lsb_reply_en;
    logic [31:0] lsb_reply_data;
    logic        flush_signal;

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_query_en    (if_query_en),
        .if_query_addr  (if_query_addr),
        .if_reply_en    (if_reply_en),
        .if_reply_data  (if_reply_data),
        .lsb_query_en   (lsb_query_en),
        .lsb_query_type (lsb_query_type),
        .lsb_query_addr (lsb_query_addr),
        .lsb_data_width (lsb_data_width),
        .lsb_query_data (lsb_query_data),
        .lsb_reply_en   (lsb_reply_en),
        .lsb_reply_data (lsb_reply_data),
        .flush_signal   (flush_signal)
    );

    always #5 clk_in = ~clk_in;

    // Posedge counter: after edge X (and during the following cycle) cyc == X
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Byte RAM: data for the address driven in one cycle appears the next
    logic [7:0] ram [logic [31:0]];
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction
    always @(posedge clk_in) if (rdy_in) mem_din <= ram_rd(mem_a);

    // Scoreboard
    typedef struct { logic is_lsb; logic [31:0] data; int cyc; } rep_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
    rep_t rep_q[$];
    wr_t  wr_q[$];
    rep_t re;
    wr_t  we;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h, want none (t=%0t)", nm, act, $time);
    endtask

    task automatic exp_rep(input logic is_lsb, input logic [31:0] d, input int c);
        rep_q.push_back('{is_lsb, d, c});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_q.push_back('{a, d, c});
    endtask

    // Monitor: compare every reply pulse and every write strobe
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (if_reply_en || lsb_reply_en) begin
                check("reply_exclusive", {63'd0, if_reply_en & lsb_reply_en}, 64'd0);
                if (rep_q.size() == 0) begin
                    fail("reply_unexpected", {32'd0, lsb_reply_en ? lsb_reply_data : if_reply_data});
                end else begin
                    re = rep_q.pop_front();
                    check("reply_owner", {63'd0, lsb_reply_en}, {63'd0, re.is_lsb});
                    check("reply_data", {32'd0, lsb_reply_en ? lsb_reply_data : if_reply_data},
                          {32'd0, re.data});
                    check("reply_cycle", 64'(cyc), 64'(re.cyc));
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    fail("write_unexpected", {24'd0, mem_dout, mem_a});
                end else begin
                    we = wr_q.pop_front();
                    check("write_addr", {32'd0, mem_a}, {32'd0, we.a});
                    check("write_data", {56'd0, mem_dout}, {56'd0, we.d});
                    check("write_cycle", 64'(cyc), 64'(we.cyc));
                end
            end
        end
    end

    // Wait (bounded) for the requester's reply, then drop query_en at the next edge
    task automatic wait_and_drop(input bit lsb);
        int t;
        t = 0;
        do begin
            @(negedge clk_in);
            t++;
        end while (!(lsb ? lsb_reply_en : if_reply_en) && t < 60);
        if (!(lsb ? lsb_reply_en : if_reply_en)) fail("reply_timeout", {63'd0, lsb});
        @(posedge clk_in);
        #1;
        if (lsb) lsb_query_en = 1'b0;
        else     if_query_en  = 1'b0;
    endtask

    task automatic lsb_req(input logic wr, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] d);
        lsb_query_type = wr;
        lsb_data_width = w;
        lsb_query_addr = a;
        lsb_query_data = d;
        lsb_query_en   = 1'b1;
    endtask

    int g;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'hF0;

        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_signal = 1'b0;
        if_query_en = 1'b0; if_query_addr = 32'd0;
        lsb_query_en = 1'b0; lsb_query_type = 1'b0; lsb_query_addr = 32'd0;
        lsb_data_width = 2'd0; lsb_query_data = 32'd0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_mem_a",          {32'd0, mem_a},          64'd0);
        check("rst_mem_dout",       {56'd0, mem_dout},       64'd0);
        check("rst_mem_wr",         {63'd0, mem_wr},         64'd0);
        check("rst_if_reply_en",    {63'd0, if_reply_en},    64'd0);
        check("rst_lsb_reply_en",   {63'd0, lsb_reply_en},   64'd0);
        check("rst_if_reply_data",  {32'd0, if_reply_data},  64'd0);
        check("rst_lsb_reply_data", {32'd0, lsb_reply_data}, 64'd0);
        rst_in = 1'b0;

        // Fetch word 0x100: reply 5 cycles after grant, no grant in DONE
        if_query_addr = 32'h100; if_query_en = 1'b1; g = cyc + 1;
        exp_rep(1'b0, 32'h00100513, g + 5);
        wait_and_drop(1'b0);
        check("done_no_grant_mem_a", {32'd0, mem_a}, 64'd0);

        // Simultaneous: lbu 0x203 wins, fetch 0x200 follows after DONE
        if_query_addr = 32'h200; if_query_en = 1'b1;
        lsb_req(1'b0, 2'd0, 32'h203, 32'd0); g = cyc + 1;
        exp_rep(1'b1, 32'h000000F0, g + 2);
        exp_rep(1'b0, 32'hF0332211, g + 9);
        fork
            wait_and_drop(1'b1);
            wait_and_drop(1'b0);
        join

        // sh 0x1001: two consecutive byte writes, one reply
        lsb_req(1'b1, 2'd1, 32'h1001, 32'hABCD1234); g = cyc + 1;
        exp_wr(32'h1001, 8'h34, g);
        exp_wr(32'h1002, 8'h12, g + 1);
        exp_rep(1'b1, 32'hABCD1234, g + 2);
        wait_and_drop(1'b1);

        // sw to IO window with the sink full for 3 cycles on byte 1
        lsb_req(1'b1, 2'd2, 32'h30000, 32'h89ABCDEF); g = cyc + 1;
        exp_wr(32'h30000, 8'hEF, g);
        exp_wr(32'h30001, 8'hCD, g + 4);
        exp_wr(32'h30002, 8'hAB, g + 5);
        exp_wr(32'h30003, 8'h89, g + 6);
        exp_rep(1'b1, 32'h89ABCDEF, g + 7);
        fork
            begin
                @(posedge clk_in); #1 io_buffer_full = 1'b1;
                repeat (3) @(posedge clk_in);
                #1 io_buffer_full = 1'b0;
            end
            wait_and_drop(1'b1);
        join

        // Flush during the second byte of lw 0x400: aborted, then fetch works
        lsb_req(1'b0, 2'd2, 32'h400, 32'd0); g = cyc + 1;
        repeat (2) @(posedge clk_in);
        #1;
        flush_signal = 1'b1; lsb_query_en = 1'b0;
        @(posedge clk_in);
        #1;
        flush_signal = 1'b0;
        check("flush_rd_mem_a", {32'd0, mem_a}, 64'd0);
        if_query_addr = 32'h100; if_query_en = 1'b1; g = cyc + 1;
        exp_rep(1'b0, 32'h00100513, g + 5);
        wait_and_drop(1'b0);

        // Flush during sw 0x2000: all four bytes still written and replied
        lsb_req(1'b1, 2'd2, 32'h2000, 32'h11223344); g = cyc + 1;
        exp_wr(32'h2000, 8'h44, g);
        exp_wr(32'h2001, 8'h33, g + 1);
        exp_wr(32'h2002, 8'h22, g + 2);
        exp_wr(32'h2003, 8'h11, g + 3);
        exp_rep(1'b1, 32'h11223344, g + 4);
        fork
            begin
                repeat (2) @(posedge clk_in);
                #1 flush_signal = 1'b1;
                @(posedge clk_in);
                #1 flush_signal = 1'b0;
            end
            wait_and_drop(1'b1);
        join

        // rdy_in low for 2 cycles mid-read: address holds, reply 2 cycles late
        if_query_addr = 32'h100; if_query_en = 1'b1; g = cyc + 1;
        exp_rep(1'b0, 32'h00100513, g + 7);
        fork
            begin
                repeat (3) @(posedge clk_in);
                #1 rdy_in = 1'b0;
                @(posedge clk_in);
                #1 check("stall_mem_a_1", {32'd0, mem_a}, 64'h102);
                @(posedge clk_in);
                #1 check("stall_mem_a_2", {32'd0, mem_a}, 64'h102);
                rdy_in = 1'b1;
            end
            wait_and_drop(1'b0);
        join

        repeat (4) @(posedge clk_in);
        #1;
        check("reply_queue_drained", 64'(rep_q.size()), 64'd0);
        check("write_queue_drained", 64'(wr_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sole owner of the byte-serial RAM/IO port.
- Arbitrates between the instruction fetch unit (word reads only) and the load/store buffer (1/2/4-byte reads and writes).
- Serialises each access into byte transfers, reassembles read data little-endian and returns a one-cycle reply pulse to the granted requester.
- Sits between the CPU core and the top-level RAM/IO bus.

Parameters:
- IO_SEL, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global enable; low freezes all state
- mem_din  input  8  RAM/IO read byte, valid the cycle after its address is driven
- mem_dout  output  8  write byte
- mem_a  output  32  byte address
- mem_wr  output  1  1 = write this cycle
- io_buffer_full  input  1  IO write sink cannot accept a byte
- if_query_en  input  1  fetch request, held high until reply
- if_query_addr  input  32  fetch word address
- if_reply_en  output  1  one-cycle pulse, fetch data valid
- if_reply_data  output  32  fetched word
- lsb_query_en  input  1  LSB request, held high until reply
- lsb_query_type  input  1  0 read, 1 write
- lsb_query_addr  input  32  access address
- lsb_data_width  input  2  0 byte, 1 half, 2 word
- lsb_query_data  input  32  write data, low bytes used
- lsb_reply_en  output  1  one-cycle pulse, access done
- lsb_reply_data  output  32  read data, zero-extended
- flush_signal  input  1  pipeline flush from RoB

Behaviour:
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, if_reply_en=0, lsb_reply_en=0, reply data=0, state=IDLE.
- rdy_in low: no register changes.
- States: IDLE, READ, WRITE, DONE.
- IDLE grant priority:
  - lsb_query_en beats if_query_en.
  - At the grant edge, latch owner, type, addr, n (1/2/4) and write data; drive byte 0 (mem_a=addr).
  - Write grant sets mem_wr=1 and mem_dout=data[7:0] → WRITE.
  - Read grant → READ.
  - Byte counter k=0.
- READ:
  - Address of byte k is driven in the cycle after edge E_k.
  - mem_din for byte k is sampled at edge E_(k+2) and placed in result bits [8k+7:8k].
  - Addresses advance addr+1 … addr+n-1.
  - At the edge sampling the last byte (E_(n+1)), pulse the owner's reply_en with the assembled data.
  - Unused upper bytes are 0.
  - Latency from grant edge to reply-high cycle is n+1 cycles: word = 5, byte = 2.
  - mem_a returns to 0 after the last address.
- WRITE:
  - Byte k is driven with mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - If addr[17:16]==IO_SEL and io_buffer_full=1, hold the current byte with mem_wr=0 and retry next cycle without advancing k.
  - After the last byte, mem_wr=0 and lsb_reply_en pulses; lsb_reply_data=lsb write data (debug).
- DONE:
  - Exactly one cycle following any reply; no grant is made.
  - Requesters drop query_en the edge after seeing reply, so this cycle prevents a stale re-grant.
  - Then → IDLE.
- Reply pulses are high for exactly one cycle; if_reply_en and lsb_reply_en are never high together.
- flush_signal, with rdy_in high:
  - IDLE/DONE: no effect beyond suppressing the grant that cycle.
  - READ: abort immediately, no reply, mem_a=0, → IDLE.
  - WRITE: complete all remaining bytes (a store is already committed); the reply is still pulsed.
  - A flush in the same cycle as a reply pulse does not cancel that pulse.
- Simultaneous requests: LSB granted; fetch waits with if_query_en held and is granted in the next IDLE.
- Address arithmetic wraps modulo 2^32; there is no alignment requirement.
- Reset mid-operation returns to reset values at the next edge; the partial write is not completed.

Decomposition:
- Shared package:
  - width encodings WIDTH_BYTE=0, WIDTH_HALF=1, WIDTH_WORD=2
  - query type constants READ=0, WRITE=1
  - state encoding IDLE/READ/WRITE/DONE
  - IO_SEL
- Single module; no sub-module is natural. The byte-count decode (width→n) is a package function.

Test Plan:
- Fetch only: if_query_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 → if_reply_en high 5 cycles after grant, if_reply_data=0x00100513, then one DONE cycle with no grant.
- Both requesters assert in the same cycle (LSB lbu addr 0x203, byte 0xF0) → LSB granted first, lsb_reply_data=0x000000F0 2 cycles after grant; fetch granted after DONE.
- LSB sh addr 0x1001, data 0xABCD1234 → mem_wr=1 on two consecutive cycles: (0x1001,0x34) then (0x1002,0x12); single lsb_reply_en pulse.
- sw to 0x30000 with io_buffer_full high for 3 cycles on byte 1 → byte 0 written, mem_wr=0 for 3 cycles, bytes 1–3 follow; total 7 cycles to reply.
- Flush during the second byte of an lw → no lsb_reply_en, mem_a=0 next cycle, IDLE, a new fetch granted normally; a flush during sw → all 4 bytes written and reply pulsed.
- rdy_in low for 2 cycles mid-read → mem_a and the byte counter hold; reply delayed by exactly 2 cycles with correct data.
